// File: rtl/dma_chunk_sequencer.sv
// Splits one host DMA request into ATA DMA EXT commands of at most MAX_CHUNK sectors,
// programming the shadow registers, issuing each command and waiting for its completion.
module dma_chunk_sequencer #(
    parameter int unsigned MAX_CHUNK = 256,
    parameter logic [7:0]  CMD_READ  = 8'h25,
    parameter logic [7:0]  CMD_WRITE = 8'h35,
    parameter logic [7:0]  DEV_VAL   = 8'h40
) (
    input  logic         sclk,
    input  logic         rst_n,
    input  logic         dma_start,
    input  logic         dma_type,
    input  logic [31:7]  mem_address,
    input  logic [31:0]  lba,
    input  logic [31:0]  sector_cnt,
    input  logic         dma_abort,
    output logic         busy,
    output logic         dma_done,
    output logic         dma_err,
    output logic [23:0]  sh_lba_lo,
    output logic         sh_lba_lo_val,
    output logic [23:0]  sh_lba_hi,
    output logic         sh_lba_hi_val,
    output logic [15:0]  sh_count,
    output logic         sh_count_val,
    output logic [7:0]   sh_dev,
    output logic         sh_dev_val,
    output logic [7:0]   sh_command,
    output logic         sh_command_val,
    output logic         cmd_issue,
    input  logic         cmd_done,
    input  logic         cmd_err,
    output logic         xfer_start,
    output logic [31:7]  xfer_addr,
    output logic [15:0]  xfer_sectors,
    output logic         xfer_dir
);

    typedef enum logic [3:0] {
        IDLE, LOAD, WR_LO, WR_HI, WR_CNT, WR_DEV, WR_CMD, ISSUE, WAIT, DONE
    } state_t;

    state_t       state, state_nxt;
    logic [31:7]  addr;
    logic [47:0]  cur_lba;
    logic [31:0]  remaining;
    logic [15:0]  chunk;
    logic         dir;
    logic         abort_pend;
    logic         err;

    logic [31:7]  addr_nxt;
    logic [31:0]  rem_nxt;
    logic         abort_any;
    logic         xfer_active;

    function automatic logic [15:0] min_chunk(input logic [31:0] rem);
        logic [31:0] max_w;
        max_w = 32'(MAX_CHUNK);
        return (rem < max_w) ? rem[15:0] : max_w[15:0];
    endfunction

    assign addr_nxt  = addr + 25'({chunk, 2'b00});
    assign rem_nxt   = remaining - 32'(chunk);
    assign abort_any = abort_pend | dma_abort;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (dma_start) state_nxt = (sector_cnt == 32'd0) ? DONE : LOAD;
            LOAD:   state_nxt = dma_abort ? DONE : WR_LO;
            WR_LO:  state_nxt = dma_abort ? DONE : WR_HI;
            WR_HI:  state_nxt = dma_abort ? DONE : WR_CNT;
            WR_CNT: state_nxt = dma_abort ? DONE : WR_DEV;
            WR_DEV: state_nxt = dma_abort ? DONE : WR_CMD;
            WR_CMD: state_nxt = dma_abort ? DONE : ISSUE;
            ISSUE:  state_nxt = dma_abort ? DONE : WAIT;
            WAIT: begin
                // An issued command always runs to completion; abort only takes effect here
                if (cmd_done)
                    state_nxt = (cmd_err || rem_nxt == 32'd0 || abort_any) ? DONE : LOAD;
            end
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state      <= IDLE;
            err        <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (dma_start) begin
                        err        <= 1'b0;
                        abort_pend <= 1'b0;
                    end
                end
                LOAD, WR_LO, WR_HI, WR_CNT, WR_DEV, WR_CMD, ISSUE: begin
                    if (dma_abort) err <= 1'b1;
                end
                WAIT: begin
                    if (dma_abort) abort_pend <= 1'b1;
                    if (cmd_done && (cmd_err || abort_any)) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Request parameters are only captured in IDLE; data registers need no reset
    // because every output that carries them is gated by state.
    always_ff @(posedge sclk) begin
        case (state)
            IDLE: begin
                if (dma_start) begin
                    addr      <= mem_address;
                    cur_lba   <= {16'h0000, lba};
                    remaining <= sector_cnt;
                    dir       <= dma_type;
                end
            end
            LOAD: chunk <= min_chunk(remaining);
            WAIT: begin
                if (cmd_done && !cmd_err) begin
                    addr      <= addr_nxt;
                    cur_lba   <= cur_lba + 48'(chunk);
                    remaining <= rem_nxt;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state != IDLE);
    assign dma_done = (state == DONE);
    assign dma_err  = err;

    assign sh_lba_lo_val  = (state == WR_LO);
    assign sh_lba_hi_val  = (state == WR_HI);
    assign sh_count_val   = (state == WR_CNT);
    assign sh_dev_val     = (state == WR_DEV);
    assign sh_command_val = (state == WR_CMD);

    assign sh_lba_lo  = sh_lba_lo_val  ? cur_lba[23:0]  : 24'h0;
    assign sh_lba_hi  = sh_lba_hi_val  ? cur_lba[47:24] : 24'h0;
    assign sh_count   = sh_count_val   ? chunk          : 16'h0;
    assign sh_dev     = sh_dev_val     ? DEV_VAL        : 8'h00;
    assign sh_command = sh_command_val ? (dir ? CMD_WRITE : CMD_READ) : 8'h00;

    assign cmd_issue   = (state == ISSUE);
    assign xfer_start  = (state == ISSUE);
    assign xfer_active = (state == ISSUE) || (state == WAIT);

    assign xfer_addr    = xfer_active ? addr  : 25'h0;
    assign xfer_sectors = xfer_active ? chunk : 16'h0;
    assign xfer_dir     = xfer_active ? dir   : 1'b0;

endmodule

// File: tb/tb_dma_chunk_sequencer.sv
// Randomized scoreboard bench for dma_chunk_sequencer: a request-level model predicts
// every output event with its cycle; a monitor pops and compares as the DUT emits them.
module tb_dma_chunk_sequencer;
    localparam int MC = 16;
    localparam int K_LO = 0, K_HI = 1, K_CNT = 2, K_DEV = 3, K_CMD = 4, K_ISSUE = 5, K_DONE = 6;

    logic sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic rst_n, dma_start, dma_type, dma_abort, cmd_done, cmd_err;
    logic [31:7] mem_address;
    logic [31:0] lba, sector_cnt;
    logic busy, dma_done, dma_err, cmd_issue, xfer_start, xfer_dir;
    logic [23:0] sh_lba_lo, sh_lba_hi;
    logic [15:0] sh_count, xfer_sectors;
    logic [7:0]  sh_dev, sh_command;
    logic sh_lba_lo_val, sh_lba_hi_val, sh_count_val, sh_dev_val, sh_command_val;
    logic [31:7] xfer_addr;

    dma_chunk_sequencer #(.MAX_CHUNK(MC)) dut (
        .sclk(sclk), .rst_n(rst_n), .dma_start(dma_start), .dma_type(dma_type),
        .mem_address(mem_address), .lba(lba), .sector_cnt(sector_cnt), .dma_abort(dma_abort),
        .busy(busy), .dma_done(dma_done), .dma_err(dma_err),
        .sh_lba_lo(sh_lba_lo), .sh_lba_lo_val(sh_lba_lo_val),
        .sh_lba_hi(sh_lba_hi), .sh_lba_hi_val(sh_lba_hi_val),
        .sh_count(sh_count), .sh_count_val(sh_count_val),
        .sh_dev(sh_dev), .sh_dev_val(sh_dev_val),
        .sh_command(sh_command), .sh_command_val(sh_command_val),
        .cmd_issue(cmd_issue), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .xfer_start(xfer_start), .xfer_addr(xfer_addr), .xfer_sectors(xfer_sectors),
        .xfer_dir(xfer_dir)
    );

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        int          kind;
        logic [63:0] data;
    } ev_t;
    ev_t exq[$];

    int dly[64];
    bit cerr[64];
    int resp_idx = 0;

    function automatic void push(input int c, input int k, input logic [63:0] d);
        ev_t e;
        e.cyc = c; e.kind = k; e.data = d;
        exq.push_back(e);
    endfunction

    task automatic chk_ev(input int k, input logic [63:0] d);
        ev_t e;
        checks++;
        if (exq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d data=%0h required no event", k, cyc, d);
        end else begin
            e = exq.pop_front();
            if (e.kind != k || e.cyc != cyc || e.data != d) begin
                failures++;
                $display("FAIL event got kind=%0d cyc=%0d data=%0h required kind=%0d cyc=%0d data=%0h",
                         k, cyc, d, e.kind, e.cyc, e.data);
            end
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {busy, dma_done, dma_err, sh_lba_lo, sh_lba_lo_val, sh_lba_hi, sh_lba_hi_val,
                sh_count, sh_count_val, sh_dev, sh_dev_val, sh_command, sh_command_val,
                cmd_issue, xfer_start, xfer_addr, xfer_sectors, xfer_dir};
    endfunction

    // Monitor
    initial begin
        forever begin
            @(negedge sclk);
            if (sh_lba_lo_val)  chk_ev(K_LO,  64'(sh_lba_lo));
            if (sh_lba_hi_val)  chk_ev(K_HI,  64'(sh_lba_hi));
            if (sh_count_val)   chk_ev(K_CNT, 64'(sh_count));
            if (sh_dev_val)     chk_ev(K_DEV, 64'(sh_dev));
            if (sh_command_val) chk_ev(K_CMD, 64'(sh_command));
            if (cmd_issue || xfer_start)
                chk_ev(K_ISSUE, 64'({cmd_issue, xfer_start, xfer_dir, xfer_sectors, xfer_addr}));
            if (dma_done)       chk_ev(K_DONE, 64'(dma_err));
        end
    end

    // Command-control responder
    initial begin
        int d;
        bit e;
        cmd_done = 1'b0;
        cmd_err  = 1'b0;
        forever begin
            @(negedge sclk);
            if (cmd_issue) begin
                d = dly[resp_idx % 64];
                e = cerr[resp_idx % 64];
                resp_idx++;
                repeat (d) @(negedge sclk);
                cmd_done = 1'b1;
                cmd_err  = e;
                @(negedge sclk);
                cmd_done = 1'b0;
                cmd_err  = 1'b0;
            end
        end
    end

    // Request-level reference: am 0=none, 1=abort at offset ao of chunk ak's setup, 2=abort in ak's WAIT
    task automatic build(input int t0, input logic [31:7] ad, input logic [31:0] lb,
                         input logic [31:0] cnt, input bit dir, input int am, input int ak,
                         input int ao, input int ec, output int ab, output bit xe);
        logic [24:0] a;
        logic [47:0] l;
        longint rem;
        int t, ch, stop, dc;
        a = ad; l = {16'h0, lb}; rem = longint'(cnt); t = t0; ab = -1; xe = 1'b0;
        if (cnt == 0) begin
            push(t0 + 1, K_DONE, 64'd0);
            return;
        end
        for (int k = 0; k < 1000; k++) begin
            ch = (rem < MC) ? int'(rem) : MC;
            stop = (am == 1 && k == ak) ? ao : 7;
            if (am == 1 && k == ak) ab = t + ao;
            if (am == 2 && k == ak) ab = t + 8;
            if (stop >= 2) push(t + 2, K_LO, 64'(l[23:0]));
            if (stop >= 3) push(t + 3, K_HI, 64'(l[47:24]));
            if (stop >= 4) push(t + 4, K_CNT, 64'(ch));
            if (stop >= 5) push(t + 5, K_DEV, 64'h40);
            if (stop >= 6) push(t + 6, K_CMD, dir ? 64'h35 : 64'h25);
            if (stop >= 7) push(t + 7, K_ISSUE, 64'({2'b11, dir, 16'(ch), a}));
            if (am == 1 && k == ak) begin
                xe = 1'b1;
                push(t + stop + 1, K_DONE, 64'd1);
                return;
            end
            dc = t + 7 + dly[k];
            if (k == ec) begin
                xe = 1'b1;
                push(dc + 1, K_DONE, 64'd1);
                return;
            end
            a = a + 25'(ch * 4);
            l = l + 48'(ch);
            rem = rem - ch;
            if (rem == 0 || (am == 2 && k == ak)) begin
                xe = (am == 2 && k == ak);
                push(dc + 1, K_DONE, 64'(xe));
                return;
            end
            t = dc;
        end
    endtask

    task automatic run_req(input logic [31:7] ad, input logic [31:0] lb, input logic [31:0] cnt,
                           input bit dir, input int am, input int ak, input int ao, input int ec,
                           input bit spur, input int rst_rel);
        int t0, ab, n;
        bit xe, fin;
        for (int i = 0; i < 64; i++) begin
            dly[i]  = $urandom_range(1, 8);
            cerr[i] = (i == ec);
        end
        if (am == 2 && dly[ak] < 2) dly[ak] = 2;
        if (rst_rel != 0) dly[0] = 20;
        resp_idx = 0;
        @(negedge sclk);
        t0 = cyc;
        mem_address = ad; lba = lb; sector_cnt = cnt; dma_type = dir;
        dma_start = 1'b1;
        build(t0, ad, lb, cnt, dir, am, ak, ao, ec, ab, xe);
        fin = 1'b0;
        for (n = 0; n < 3000 && !fin; n++) begin
            @(negedge sclk);
            dma_start = 1'b0;
            if (spur && cyc == t0 + 3) begin
                dma_start   = 1'b1;
                mem_address = 25'($urandom);
                lba         = $urandom;
                sector_cnt  = $urandom_range(1, 200);
                dma_type    = ~dir;
            end
            dma_abort = (cyc == ab);
            if (rst_rel != 0 && cyc == t0 + rst_rel) begin
                rst_n = 1'b0;
                while (exq.size() != 0 && exq[$].cyc > cyc) void'(exq.pop_back());
                xe = 1'b0;
            end else if (rst_rel != 0 && cyc == t0 + rst_rel + 1) begin
                rst_n = 1'b1;
                checks++;
                if (all_outs() != 128'h0) begin
                    failures++;
                    $display("FAIL mid_reset_outputs got=%0h required=0", all_outs());
                end
                fin = 1'b1;
            end
            if (dma_done) fin = 1'b1;
        end
        dma_start = 1'b0;
        dma_abort = 1'b0;
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL request_timeout got no dma_done required dma_done within 3000 cycles");
        end
        repeat (30) @(negedge sclk);
        checks++;
        if (exq.size() != 0) begin
            failures++;
            $display("FAIL missing_events got %0d pending required 0", exq.size());
            exq.delete();
        end
        checks++;
        if (busy !== 1'b0 || dma_err !== xe) begin
            failures++;
            $display("FAIL idle_status got busy=%0b dma_err=%0b required busy=0 dma_err=%0b", busy, dma_err, xe);
        end
    endtask

    initial begin
        int cnt, nch, am, ak, ao, ec;
        rst_n = 1'b0; dma_start = 1'b0; dma_type = 1'b0; dma_abort = 1'b0;
        mem_address = '0; lba = '0; sector_cnt = '0;
        repeat (3) @(negedge sclk);
        checks++;
        if (all_outs() != 128'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%0h required=0", all_outs());
        end
        rst_n = 1'b1;
        repeat (2) @(negedge sclk);

        run_req(25'(32'h0100_0000 >> 7), 32'h1000, 32'd10, 1'b0, 0, 0, 0, -1, 1'b0, 0);
        run_req(25'h1FF_FFFF, 32'h200, 32'd40, 1'b1, 0, 0, 0, -1, 1'b0, 0);
        run_req(25'h123, 32'hFFFF_FFF0, 32'd32, 1'b0, 0, 0, 0, -1, 1'b0, 0);
        run_req(25'h456, 32'h10, 32'd40, 1'b1, 0, 0, 0, 0, 1'b1, 0);
        run_req(25'h789, 32'h20, 32'd40, 1'b0, 1, 0, 4, -1, 1'b0, 0);
        run_req(25'h789, 32'h20, 32'd40, 1'b0, 2, 0, 0, -1, 1'b0, 0);
        run_req(25'h111, 32'h30, 32'd0, 1'b1, 0, 0, 0, -1, 1'b0, 0);
        run_req(25'h222, 32'h40, 32'd10, 1'b0, 0, 0, 0, -1, 1'b0, 10);

        for (int r = 0; r < 40; r++) begin
            cnt = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 100);
            nch = (cnt + MC - 1) / MC;
            am = 0; ak = 0; ao = 1; ec = -1;
            if (nch > 0) begin
                am = $urandom_range(0, 2);
                ak = $urandom_range(0, nch - 1);
                ao = $urandom_range(1, 7);
                if ($urandom_range(0, 3) == 0) ec = $urandom_range(0, nch - 1);
            end
            run_req(25'($urandom), $urandom, 32'(cnt), 1'($urandom), am, ak, ao, ec,
                    1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dma_chunk_sequencer.md
# dma_chunk_sequencer

Sequences one host-programmed DMA request (address, LBA, sector count, direction) into a series of ATA DMA EXT commands, each at most MAX_CHUNK sectors. For each chunk it programs the shadow registers, issues the command to command control, hands address and length to the DMA engine, and waits for completion. It sits in the sclk domain between the DMA register file and the shadow-register and command-control blocks.

## Interface
- MAX_CHUNK, 256: maximum sectors per ATA command; legal range 1..65535.
- CMD_READ, 8'h25: READ DMA EXT opcode.
- CMD_WRITE, 8'h35: WRITE DMA EXT opcode.
- DEV_VAL, 8'h40: device register value (LBA mode).
- sclk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- dma_start  in  1  one-cycle request pulse; ignored while busy.
- dma_type  in  1  1 = memory-to-device (write), 0 = device-to-memory (read).
- mem_address  in  [31:7]  start buffer address, 128-byte units.
- lba  in  32  start LBA, zero-extended to 48 bits.
- sector_cnt  in  32  total sectors.
- dma_abort  in  1  level/pulse; request early termination.
- busy  out  1  high from the cycle after dma_start until dma_done.
- dma_done  out  1  one-cycle completion pulse.
- dma_err  out  1  status of last request; valid from dma_done until next accepted start.
- sh_lba_lo / sh_lba_lo_val  out  24 / 1  LBA[23:0] write.
- sh_lba_hi / sh_lba_hi_val  out  24 / 1  LBA[47:24] write.
- sh_count / sh_count_val  out  16 / 1  chunk sector count write.
- sh_dev / sh_dev_val  out  8 / 1  device register write.
- sh_command / sh_command_val  out  8 / 1  command opcode write.
- cmd_issue  out  1  one-cycle pulse to command control.
- cmd_done  in  1  one-cycle chunk completion pulse.
- cmd_err  in  1  sampled only when cmd_done=1.
- xfer_start  out  1  one-cycle pulse to the DMA engine, coincident with cmd_issue.
- xfer_addr  out  [31:7]  chunk buffer address; stable from xfer_start through WAIT.
- xfer_sectors  out  16  chunk length.
- xfer_dir  out  1  latched dma_type.

## Operation
- Registered state: addr[31:7], cur_lba[47:0], remaining[31:0], chunk[15:0], dir, abort_pend, err.
- IDLE: on dma_start, latch all inputs, clear err and abort_pend. If sector_cnt==0 → DONE, otherwise → LOAD.
- LOAD: chunk = min(remaining, MAX_CHUNK) → WR_LO.
- WR_LO, WR_HI, WR_CNT, WR_DEV, WR_CMD: one state per cycle. Each asserts exactly one *_val for one cycle with the matching data (cur_lba[23:0], cur_lba[47:24], chunk, DEV_VAL, dir?CMD_WRITE:CMD_READ).
- ISSUE: cmd_issue=xfer_start=1 for one cycle → WAIT.
- WAIT: on cmd_done:
  - if cmd_err: set err → DONE.
  - else update addr += chunk*4 (mod 2^25), cur_lba += chunk (mod 2^48), remaining -= chunk.
  - then go to DONE if remaining==0 or abort_pend (err set for abort); otherwise go to LOAD.
- DONE: dma_done=1 for one cycle, dma_err=err → IDLE.
- dma_abort: in LOAD..ISSUE, go to DONE next cycle with err=1; no further shadow writes and no cmd_issue. In WAIT, set abort_pend; the issued command is always allowed to complete. In IDLE/DONE it is ignored.
- dma_start outside IDLE is ignored entirely, and the latched parameters are unchanged.
- Address and LBA arithmetic wraps silently; no error is raised.

## Timing
- Reset (rst_n=0 at a clock edge): state IDLE. All outputs 0 (busy, dma_done, dma_err, all *_val, all data buses, cmd_issue, xfer_*). A reset mid-request abandons it with no dma_done.
- Start sampled at cycle 0: LOAD at 1, sh_lba_lo_val at 2, lba_hi 3, count 4, dev 5, command 6, cmd_issue/xfer_start at 7, WAIT from 8.
- cmd_done at cycle N: LOAD at N+1 (next chunk writes begin N+2) or dma_done at N+1.
- sector_cnt==0: dma_done at cycle 1, no other activity.
- Shadow data buses are don't-care when their *_val is 0, but are driven to 0 in IDLE.
- cmd_done outside WAIT is ignored.

## Test plan
- lba=0x1000, cnt=100, addr=0x0100_0000>>7, read → one chunk; writes lo=0x001000, hi=0, count=100, dev=0x40, cmd=0x25 on cycles 2-6; cmd_issue at 7; dma_done the cycle after cmd_done, dma_err=0.
- cnt=600, MAX_CHUNK=256, write → chunks 256, 256, 88; lba advancing by +256 per chunk; xfer_addr advancing by +1024 per chunk; cmd=0x35; exactly 3 cmd_issue pulses, then one dma_done.
- lba=0xFFFF_FFF0, cnt=32, MAX_CHUNK=16 → second chunk sh_lba_lo=0x000000, sh_lba_hi=0x000100 (48-bit carry).
- cmd_err=1 on the first of 3 chunks → dma_done at N+1 with dma_err=1, no further cmd_issue; a second dma_start during the run is ignored.
- dma_abort at cycle 4 → no sh_dev_val, no cmd_issue, dma_done at 5 with err=1. dma_abort in WAIT → dma_done only after cmd_done, err=1.
- sector_cnt=0 → dma_done at cycle 1, err=0. rst_n low mid-WAIT → all outputs 0 next cycle, no dma_done.
